// File: rtl/costas_nco_pkg.sv
// costas_pkg: shared widths, LFSR seed, quadrant type and the quarter-wave
// folding helpers used by the Costas-loop NCO (costas_nco) and its ROM.
package costas_pkg;

    localparam int          PHASE_W   = 32;
    localparam int          LUT_AW    = 10;
    localparam int          LUT_DEPTH = 1024;
    localparam int          LUT_DW    = 15;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    // Odd quadrants walk the quarter wave backwards.
    function automatic logic [LUT_AW-1:0] fold_addr(quad_t q, logic [LUT_AW-1:0] a);
        return (q == Q1 || q == Q3) ? ~a : a;
    endfunction

    // The second half-cycle is the negated first half.
    function automatic logic quad_neg(quad_t q);
        return (q == Q2 || q == Q3);
    endfunction

endpackage

// File: rtl/costas_nco_lut.sv
// costas_nco_lut: dual-read registered quarter-wave sine ROM, 1024 x 15 bit
// unsigned. Entry k = round(32767*sin(2*pi*(k+0.5)/4096)), range 25..32767.
// Ports:
//   clk            clock
//   en             read enable (pipeline advance)
//   addr_a/addr_b  10-bit read addresses (sine / cosine)
//   data_a/data_b  registered 15-bit magnitudes
module costas_nco_lut
    import costas_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr_a,
    input  logic [LUT_AW-1:0] addr_b,
    output logic [LUT_DW-1:0] data_a,
    output logic [LUT_DW-1:0] data_b
);

    localparam real PI = 3.14159265358979323846;

    function automatic logic [LUT_DW-1:0] entry(int k);
        real x;
        x = 32767.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 4096.0);
        return LUT_DW'($rtoi(x + 0.5));
    endfunction

    logic [LUT_DW-1:0] rom [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        assign rom[k] = entry(k);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/costas_nco.sv
// costas_nco: numerically controlled oscillator for a Costas loop.
// 32-bit phase accumulator feeding a 3-stage sin/cos pipeline
// (fold -> quarter-wave ROM -> sign), advanced one sample per ce.
// Optional macro COSTAS_NCO_DITHER_EN adds LFSR phase dither ahead of the ROM
// lookup (accumulator and phase port are unaffected).
// Ports:
//   clk         clock (rising edge)
//   rst         synchronous active-low reset
//   ce          sample enable
//   freq_valid  load freq_word into the frequency register
//   freq_word   phase increment per sample
//   sin_out     signed sine sample, OUT_W bits
//   cos_out     signed cosine sample, OUT_W bits
//   out_valid   one-cycle pulse after each new sin_out/cos_out pair
//   phase       current accumulator value
module costas_nco
    import costas_pkg::*;
#(
    parameter logic [31:0] START_FREQ = 32'h2000_0000,
    parameter int          OUT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    freq_valid,
    input  logic [31:0]             freq_word,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    out_valid,
    output logic [31:0]             phase
);

    logic [PHASE_W-1:0] freq_reg;
    logic [11:0]        lut_idx;

`ifdef COSTAS_NCO_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else if (ce) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Only the top 12 bits of the dithered phase are needed; the add still
    // spans the full width so carries from the dither reach the index.
    assign lut_idx = 12'((phase + {12'b0, lfsr, 4'b0}) >> 20);
`else
    assign lut_idx = phase[31:20];
`endif

    quad_t             q_s;
    quad_t             q_c;
    logic [LUT_AW-1:0] addr;

    always_comb begin
        q_s  = quad_t'(lut_idx[11:10]);
        q_c  = quad_t'(lut_idx[11:10] + 2'd1);
        addr = lut_idx[9:0];
    end

    // Stage 1: folded addresses and signs.
    logic              s1_valid;
    logic [LUT_AW-1:0] s1_addr_s;
    logic [LUT_AW-1:0] s1_addr_c;
    logic              s1_neg_s;
    logic              s1_neg_c;

    // Stage 2: ROM outputs (registered in the LUT) plus delayed signs.
    logic              s2_valid;
    logic              s2_neg_s;
    logic              s2_neg_c;
    logic [LUT_DW-1:0] mag_s;
    logic [LUT_DW-1:0] mag_c;

    costas_nco_lut u_lut (
        .clk    (clk),
        .en     (ce),
        .addr_a (s1_addr_s),
        .addr_b (s1_addr_c),
        .data_a (mag_s),
        .data_b (mag_c)
    );

    // Stage 3 inputs: magnitude <= 32767, so negation cannot overflow 16 bits.
    logic signed [15:0] val_s;
    logic signed [15:0] val_c;

    always_comb begin
        val_s = signed'({1'b0, mag_s});
        val_c = signed'({1'b0, mag_c});
        if (s2_neg_s) val_s = -val_s;
        if (s2_neg_c) val_c = -val_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase     <= '0;
            freq_reg  <= START_FREQ;
            s1_valid  <= 1'b0;
            s1_addr_s <= '0;
            s1_addr_c <= '0;
            s1_neg_s  <= 1'b0;
            s1_neg_c  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_neg_s  <= 1'b0;
            s2_neg_c  <= 1'b0;
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (freq_valid) begin
                freq_reg <= freq_word;
            end
            if (ce) begin
                phase     <= phase + freq_reg;
                s1_valid  <= 1'b1;
                s1_addr_s <= fold_addr(q_s, addr);
                s1_addr_c <= fold_addr(q_c, addr);
                s1_neg_s  <= quad_neg(q_s);
                s1_neg_c  <= quad_neg(q_c);
                s2_valid  <= s1_valid;
                s2_neg_s  <= s1_neg_s;
                s2_neg_c  <= s1_neg_c;
                if (s2_valid) begin
                    sin_out   <= OUT_W'(val_s);
                    cos_out   <= OUT_W'(val_c);
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_costas_nco.sv
// tb_costas_nco: table-driven directed vectors plus randomized stimulus
// checked against a behavioural NCO model for costas_nco.
module tb_costas_nco;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               ce = 1'b0;
    logic               freq_valid = 1'b0;
    logic [31:0]        freq_word = '0;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;
    logic               out_valid;
    logic [31:0]        phase;

    costas_nco #(
        .START_FREQ (32'h2000_0000),
        .OUT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .freq_valid (freq_valid),
        .freq_word  (freq_word),
        .sin_out    (sin_out),
        .cos_out    (cos_out),
        .out_valid  (out_valid),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    localparam real PI = 3.14159265358979323846;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: accumulator, frequency, and the samples in flight.
    logic [31:0] m_phase = '0;
    logic [31:0] m_freq  = 32'h2000_0000;
    logic [31:0] m_pipe[$];
    int          m_sin = 0;
    int          m_cos = 0;
    logic        m_ov  = 1'b0;

    // Full-wave reference: 4096 points per cycle, sampled at bin centres.
    function automatic int ref_sample(logic [31:0] ph);
        int  p;
        int  m;
        real s;
        p = int'(ph[31:20]);
        s = $sin(2.0 * PI * (real'(p) + 0.5) / 4096.0);
        m = $rtoi(32767.0 * ((s < 0.0) ? -s : s) + 0.5);
        return (s < 0.0) ? -m : m;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic r, input logic c, input logic fv, input logic [31:0] fw);
        logic [31:0] ph;
        rst = r; ce = c; freq_valid = fv; freq_word = fw;
        @(posedge clk);
        if (!r) begin
            m_phase = '0;
            m_freq  = 32'h2000_0000;
            m_pipe.delete();
            m_sin = 0;
            m_cos = 0;
            m_ov  = 1'b0;
        end else begin
            m_ov = 1'b0;
            if (c) begin
                m_pipe.push_back(m_phase);
                m_phase = m_phase + m_freq;
                if (m_pipe.size() == 3) begin
                    ph    = m_pipe.pop_front();
                    m_sin = ref_sample(ph);
                    m_cos = ref_sample(ph + 32'h4000_0000);
                    m_ov  = 1'b1;
                end
            end
            if (fv) m_freq = fw;
        end
        #1;
        chk("model_phase", phase, m_phase);
        chk("model_out_valid", out_valid, m_ov);
        chk("model_sin", sin_out, m_sin);
        chk("model_cos", cos_out, m_cos);
    endtask

    typedef struct {
        logic        r;
        logic        c;
        logic        fv;
        logic [31:0] fw;
        logic [31:0] ph;
        logic        ov;
        logic        chk_out;
        int          s;
        int          co;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic c, logic fv, logic [31:0] fw,
                                logic [31:0] ph, logic ov, logic chk_out, int s, int co);
        vec_t v;
        v.r = r; v.c = c; v.fv = fv; v.fw = fw;
        v.ph = ph; v.ov = ov; v.chk_out = chk_out; v.s = s; v.co = co;
        tbl.push_back(v);
    endfunction

    initial begin
        // Reset wins over ce/freq_valid; freq change lands on the 2nd ce,
        // then quarter-turn stepping gives the four cardinal samples.
        add(0, 1, 1, 32'h0000_0123, 32'h0000_0000, 0, 1, 0, 0);
        add(1, 1, 0, 0,             32'h2000_0000, 0, 1, 0, 0);
        add(1, 1, 1, 32'h4000_0000, 32'h4000_0000, 0, 1, 0, 0);
        add(1, 1, 0, 0,             32'h8000_0000, 1, 1, 25, 32767);
        add(1, 1, 0, 0,             32'hC000_0000, 1, 0, 0, 0);
        add(1, 1, 0, 0,             32'h0000_0000, 1, 1, 32767, -25);
        add(1, 1, 0, 0,             32'h4000_0000, 1, 1, -25, -32767);
        add(1, 1, 0, 0,             32'h8000_0000, 1, 1, -32767, 25);
        add(1, 1, 0, 0,             32'hC000_0000, 1, 1, 25, 32767);
        add(1, 0, 0, 0,             32'hC000_0000, 0, 1, 25, 32767);
        add(1, 1, 0, 0,             32'h0000_0000, 1, 1, 32767, -25);
        // Zero frequency: phase parked at 0.
        add(0, 0, 0, 0, 32'h0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 32'h0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 32'h0, 1, 1, 25, 32767);
        add(1, 1, 0, 0, 32'h0, 1, 1, 25, 32767);
        // Accumulator wrap from 0xFFFF_FFFF.
        add(0, 0, 0, 0,             32'h0000_0000, 0, 1, 0, 0);
        add(1, 0, 1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 0, 0);
        add(1, 1, 1, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 0, 0);
        add(1, 1, 0, 0,             32'h0000_0000, 0, 1, 0, 0);
        add(1, 1, 0, 0,             32'h0000_0001, 1, 1, 25, 32767);
        add(1, 1, 0, 0,             32'h0000_0002, 1, 1, -25, 32767);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].fv, tbl[i].fw);
            chk($sformatf("tbl[%0d].phase", i), phase, tbl[i].ph);
            chk($sformatf("tbl[%0d].out_valid", i), out_valid, tbl[i].ov);
            if (tbl[i].chk_out) begin
                chk($sformatf("tbl[%0d].sin", i), sin_out, tbl[i].s);
                chk($sformatf("tbl[%0d].cos", i), cos_out, tbl[i].co);
            end
        end

        // ce on alternate cycles at the default frequency.
        step(0, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            step(1, (i % 2) == 0, 0, 0);
            if ((i % 2) == 1) chk("alt_no_pulse_idle", out_valid, 0);
        end

        // Reset after 5 samples: refill takes 3 ce cycles, no stale pulse.
        step(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
        chk("pre_reset_valid", out_valid, 1);
        step(0, 1, 0, 0);
        chk("reset_valid", out_valid, 0);
        step(1, 1, 0, 0);
        chk("refill1_valid", out_valid, 0);
        step(1, 1, 0, 0);
        chk("refill2_valid", out_valid, 0);
        step(1, 1, 0, 0);
        chk("refill3_valid", out_valid, 1);
        chk("refill3_sin", sin_out, 25);
        chk("refill3_cos", cos_out, 32767);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        c;
            logic        fv;
            logic [31:0] fw;
            r  = ($urandom_range(0, 199) != 0);
            c  = ($urandom_range(0, 2) != 0);
            fv = ($urandom_range(0, 7) == 0);
            fw = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            step(r, c, fv, fw);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
